// File: rtl/adder_accumulator_if.sv
// Stream bundle for adder_accumulator: operand input, group-result output and the clear strobe.
interface adder_accumulator_if #(
  parameter int nbit = 8
);
  // Handshakes: a transfer happens on a rising clk edge where valid && ready; the producer
  // keeps valid and its data steady until that edge, and ready never depends on valid.
  logic            clear;
  logic            in_valid;
  logic            in_ready;
  logic [nbit-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [nbit-1:0] out_sum;
  logic            out_ovf;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/adder_accumulator.sv
// Sums groups of `count` operands with a sticky carry flag and hands each total to a consumer.
// Define ACC_SATURATE_EN to clamp the accumulator to all-ones on carry instead of wrapping.
module adder #(
  parameter int nbit = 8
) (
  input  logic [nbit-1:0] a,
  input  logic [nbit-1:0] b,
  output logic [nbit-1:0] s,
  output logic            cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b};
endmodule

module adder_accumulator #(
  parameter int nbit  = 8,
  parameter int count = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  adder_accumulator_if.slave   bus,
  output logic [1:0]           state_o
);
  localparam int CW = $clog2(count + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [nbit-1:0] acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [nbit-1:0] sum_q, sum_d;
  logic            sum_ovf_q, sum_ovf_d;

  logic [nbit-1:0] add_s;
  logic            add_cout;
  logic [nbit-1:0] add_val;
  logic [CW-1:0]   cnt_inc;
  logic            accept;

  adder #(.nbit(nbit)) u_adder (
    .a    (acc_q),
    .b    (bus.in_data),
    .s    (add_s),
    .cout (add_cout)
  );

`ifdef ACC_SATURATE_EN
  // All-ones plus anything nonzero carries again, so a saturated group stays saturated.
  assign add_val = add_cout ? {nbit{1'b1}} : add_s;
`else
  assign add_val = add_s;
`endif

  assign cnt_inc = cnt_q + CW'(1);

  // Handshake outputs decode from state alone.
  assign bus.in_ready  = (state_q != DONE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_ovf   = sum_ovf_q;
  assign state_o       = state_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sum_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      sum_ovf_q <= sum_ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    sum_ovf_d = sum_ovf_q;
    if (bus.clear) begin
      // Abort wins over any same-cycle accept or result handshake; the result port keeps its last total.
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d = bus.in_data;
            cnt_d = CW'(1);
            ovf_d = 1'b0;
            if (count == 1) begin
              state_d   = DONE;
              sum_d     = bus.in_data;
              sum_ovf_d = 1'b0;
            end else begin
              state_d = ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = add_val;
            ovf_d = ovf_q | add_cout;
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(count)) begin
              state_d   = DONE;
              sum_d     = add_val;
              sum_ovf_d = ovf_q | add_cout;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_accumulator.sv
// Directed and randomized checks of adder_accumulator against an arithmetic group-sum model.
module tb_adder_accumulator;
  localparam int NBIT  = 8;
  localparam int COUNT = 4;
  localparam int LIMIT = 50;

  logic       clk;
  logic       reset;
  logic [1:0] state_dbg;

  adder_accumulator_if #(.nbit(NBIT)) bus ();

  adder_accumulator #(.nbit(NBIT), .count(COUNT)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .state_o (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [NBIT-1:0] exp_q[$];
  logic            ovf_q[$];
  int              grp[COUNT];
  logic [NBIT-1:0] held_sum;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference model: group total from plain integer arithmetic
  function automatic void model_group();
    int acc;
    bit ovf;
    acc = grp[0];
    ovf = 1'b0;
    for (int i = 1; i < COUNT; i++) begin
      acc = acc + grp[i];
      if (acc >= (1 << NBIT)) begin
        ovf = 1'b1;
`ifdef ACC_SATURATE_EN
        acc = (1 << NBIT) - 1;
`else
        acc = acc - (1 << NBIT);
`endif
      end
    end
    exp_q.push_back(acc[NBIT-1:0]);
    ovf_q.push_back(ovf);
  endfunction

  // driver tasks (all activity is placed 1 time unit after a rising edge)
  task automatic feed(input int x, input string tag);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x[NBIT-1:0];
    while (!bus.in_ready && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == LIMIT) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic get_result(input string tag);
    int n;
    logic [NBIT-1:0] es;
    logic            eo;
    n = 0;
    while (!bus.out_valid && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    es = exp_q.pop_front();
    eo = ovf_q.pop_front();
    check({tag, "_sum"}, 32'(bus.out_sum), 32'(es));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_released"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_group(input string tag, input bit gaps);
    model_group();
    for (int i = 0; i < COUNT; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      feed(grp[i], tag);
    end
    get_result(tag);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_in_ready"},  32'(bus.in_ready),  32'd1);
    check({tag, "_out_sum"},   32'(bus.out_sum),   32'd0);
    check({tag, "_out_ovf"},   32'(bus.out_ovf),   32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("por_idle_ready", 32'(bus.in_ready), 32'd1);

    // 1,2,3,4 back to back with the consumer already ready
    bus.out_ready = 1'b1;
    grp = '{1, 2, 3, 4};
    model_group();
    for (int i = 0; i < COUNT; i++) feed(grp[i], "seq");
    check("seq_out_valid", 32'(bus.out_valid), 32'd1);
    check("seq_in_ready_done", 32'(bus.in_ready), 32'd0);
    check("seq_sum", 32'(bus.out_sum), 32'(exp_q.pop_front()));
    check("seq_ovf", 32'(bus.out_ovf), 32'(ovf_q.pop_front()));
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("seq_out_valid_after", 32'(bus.out_valid), 32'd0);
    check("seq_in_ready_after", 32'(bus.in_ready), 32'd1);

    // carry out of the accumulator
    grp = '{200, 100, 0, 0};
    run_group("carry", 1'b0);

    // asynchronous reset between clock edges with a partial group
    feed(5, "async");
    #3;
    reset = 1'b1;
    #1;
    check_reset_outputs("async");
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("async_idle_ready", 32'(bus.in_ready), 32'd1);
    check("async_idle_valid", 32'(bus.out_valid), 32'd0);

    // result held under backpressure while an operand waits
    grp = '{7, 7, 7, 7};
    model_group();
    for (int i = 0; i < COUNT; i++) feed(grp[i], "hold");
    held_sum = exp_q.pop_front();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd9;
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_sum", 32'(bus.out_sum), 32'(held_sum));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
    end
    check("hold_ovf", 32'(bus.out_ovf), 32'(ovf_q.pop_front()));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold_released", 32'(bus.out_valid), 32'd0);
    check("hold_idle_ready", 32'(bus.in_ready), 32'd1);
    check("hold_sum_kept", 32'(bus.out_sum), 32'(held_sum));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    grp = '{9, 1, 1, 1};
    model_group();
    for (int i = 1; i < COUNT; i++) feed(grp[i], "hold_next");
    get_result("hold_next");

    // clear drops a partial group and the same-cycle operand
    feed(10, "clear");
    feed(20, "clear");
    bus.clear    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd30;
    @(posedge clk); #1;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    check("clear_valid", 32'(bus.out_valid), 32'd0);
    check("clear_in_ready", 32'(bus.in_ready), 32'd1);
    grp = '{5, 5, 5, 5};
    run_group("clear_next", 1'b0);

    // reset held across edges in the middle of a group
    feed(1, "midreset");
    feed(2, "midreset");
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    grp = '{1, 1, 1, 1};
    run_group("midreset_next", 1'b0);

    // randomized groups with idle gaps and random consumer delay
    for (int g = 0; g < 10; g++) begin
      for (int i = 0; i < COUNT; i++) grp[i] = int'($urandom_range(0, 255));
      run_group("rand", 1'b1);
    end

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
- Sequential stage directly downstream of the combinational `adder`; instantiates one `adder #(.nbit(nbit))` and consumes its `s`/`cout`.
- Sums a group of `count` operands from a valid/ready input stream into an nbit register.
- Tracks a sticky carry-out (overflow) flag across the group.
- Presents the group total on a valid/ready output port and holds it until the consumer accepts it.

Parameters:
- nbit, 8, operand / accumulator width (same meaning as in `adder`).
- count, 4, operands per group; legal range >= 1; group counter width is $clog2(count+1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous abort of the current group.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  nbit  operand.
- out_valid  output  1  group result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  nbit  group total, modulo 2^nbit.
- out_ovf  output  1  at least one carry-out occurred in the group.

Behaviour:
- Interface fixed: one clock, clk; reset is asynchronous and active-high, port name reset.
- Reset, taking effect immediately on assertion, independent of clk:
  - state = IDLE; acc = 0; cnt = 0; ovf = 0.
  - out_valid = 0, out_sum = 0, out_ovf = 0, in_ready = 1.
  - Applies mid-group as well; a partial group is discarded.
- Datapath:
  - adder a = acc, b = in_data.
  - Accept event = in_valid && in_ready.
- States:
  - IDLE:
    - in_ready = 1, out_valid = 0.
    - On accept: acc <= in_data (adder bypassed); cnt <= 1; ovf <= 0.
    - Then go to DONE if count == 1, else ACCUM.
  - ACCUM:
    - in_ready = 1.
    - On accept: acc <= adder s; ovf <= ovf | cout; cnt <= cnt + 1.
    - If this accept makes cnt == count, go to DONE.
    - No accept: hold all state.
  - DONE:
    - in_ready = 0, out_valid = 1, out_sum = acc, out_ovf = ovf.
    - All held stable while out_ready = 0; in_valid is ignored.
    - On out_ready: go to IDLE. out_sum and out_ovf keep their last value until the next group completes.
- Latency:
  - out_valid rises on the clock edge that accepts the count-th operand.
  - One bubble cycle: the next group cannot start in the handshake cycle of the result.
- Back-to-back input: one operand per cycle whenever in_valid is held high in IDLE/ACCUM.
- clear:
  - Synchronous; highest priority after reset, including over a same-cycle accept or output handshake.
  - Next state = IDLE, acc = 0, cnt = 0, ovf = 0, out_valid = 0.
  - in_ready remains 1 during the clear cycle, but an operand presented that cycle is dropped.
- Width rule: wrap-around modulo 2^nbit; cout from each addition ORed into ovf; no wider internal sum.
- Outputs are registered or decoded from state only; no combinational path from in_* or out_ready to out_*.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined:
  - When an addition produces cout = 1, acc <= {nbit{1'b1}} instead of s.
  - Once saturated, acc stays all-ones for the rest of the group (further adds carry again).
  - ovf is set as normal.
- Undefined: plain modulo wrap as described in Behaviour.

Test Plan:
- Assert reset mid-cycle, no clk edge -> out_valid 0, in_ready 1, out_sum 0, out_ovf 0 immediately. Release reset -> remains IDLE.
- nbit=8, count=4; in_data 1, 2, 3, 4 on consecutive cycles, out_ready 1 -> out_valid high the cycle after the 4th accept, out_sum 10, out_ovf 0; in_ready 0 that cycle, 1 the next.
- Operands 200, 100, 0, 0 -> out_sum 44, out_ovf 1. With ACC_SATURATE_EN defined -> out_sum 255, out_ovf 1.
- Complete a group of 4 x 7; hold out_ready 0 for 5 cycles while in_valid 1 with in_data 9 -> out_sum 28 stable, no operand accepted. Raise out_ready -> IDLE next cycle, then operand 9 accepted.
- Accept 10, 20; pulse clear in the same cycle as an in_valid of 30 -> IDLE, 30 dropped. Next operands 5, 5, 5, 5 -> out_sum 20, out_ovf 0.
- Accept 2 of 4 operands, then assert reset asynchronously for 3 cycles -> all outputs at reset values immediately. After release, 1, 1, 1, 1 -> out_sum 4.
